// File: rtl/dbus_tx_arbiter_pkg.sv
// rtl/dbus_tx_arbiter_pkg.sv - shared dbus transmit arbiter state encoding and requester indices
package dbus_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SEND  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam int REQ_UART  = 0;
    localparam int REQ_LOCAL = 1;

endpackage

// File: rtl/dbus_tx_arbiter_if.sv
// rtl/dbus_tx_arbiter_if.sv - requester byte streams and dbus transmit port bundle
interface dbus_tx_arbiter_if;
    logic [1:0] i_req;
    logic [7:0] i_data0;
    logic [7:0] i_data1;
    logic       i_valid0;
    logic       i_valid1;
    logic       i_last0;
    logic       i_last1;
    logic       o_ready0;
    logic       o_ready1;
    logic       i_dbusbusy;
    logic [7:0] o_dbusdata;
    logic       o_dbusenable;
    logic [1:0] o_grant;
    logic       o_timeout;

    modport slave (
        input  i_req, i_data0, i_data1, i_valid0, i_valid1, i_last0, i_last1, i_dbusbusy,
        output o_ready0, o_ready1, o_dbusdata, o_dbusenable, o_grant, o_timeout
    );

    modport master (
        output i_req, i_data0, i_data1, i_valid0, i_valid1, i_last0, i_last1, i_dbusbusy,
        input  o_ready0, o_ready1, o_dbusdata, o_dbusenable, o_grant, o_timeout
    );
endinterface

// File: rtl/dbus_tx_arbiter.sv
// rtl/dbus_tx_arbiter.sv - packet-level round-robin arbiter for the shared dbus transmit port
module dbus_tx_arbiter
    import dbus_tx_arbiter_pkg::*;
#(
    parameter int c_TIMEOUT = 4000000,
    parameter int c_ACKWAIT = 16
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    dbus_tx_arbiter_if.slave bus
);
    localparam int TW = $clog2(c_TIMEOUT + 1);
    localparam int AW = $clog2(c_ACKWAIT + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(c_TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT   = TW'(c_TIMEOUT);
    localparam logic [AW-1:0] A_LIMIT = AW'(c_ACKWAIT - 1);
    localparam logic [AW-1:0] A_SAT   = AW'(c_ACKWAIT);

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    ready_q, ready_d;
    logic          last_owner_q, last_owner_d;
    logic          last_q, last_d;
    logic          enable_q, enable_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [AW-1:0] acnt_q, acnt_d;

    logic       owner;
    logic       own_valid;
    logic       own_last;
    logic [7:0] own_data;
    logic       pick;
    logic       accept;

    assign owner     = grant_q[REQ_LOCAL];
    assign own_valid = owner ? bus.i_valid1 : bus.i_valid0;
    assign own_last  = owner ? bus.i_last1  : bus.i_last0;
    assign own_data  = owner ? bus.i_data1  : bus.i_data0;
    assign accept    = |(ready_q & {bus.i_valid1, bus.i_valid0});
    // On contention the requester that did not finish most recently wins
    assign pick      = (bus.i_req == 2'b11) ? ~last_owner_q : ~bus.i_req[REQ_UART];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            ready_q      <= 2'b00;
            last_owner_q <= 1'b1;
            last_q       <= 1'b0;
            enable_q     <= 1'b0;
            timeout_q    <= 1'b0;
            data_q       <= 8'h00;
            tcnt_q       <= '0;
            acnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ready_q      <= ready_d;
            last_owner_q <= last_owner_d;
            last_q       <= last_d;
            enable_q     <= enable_d;
            timeout_q    <= timeout_d;
            data_q       <= data_d;
            tcnt_q       <= tcnt_d;
            acnt_q       <= acnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ready_d      = 2'b00;
        last_owner_d = last_owner_q;
        last_d       = last_q;
        enable_d     = 1'b0;
        timeout_d    = 1'b0;
        data_d       = 8'h00;
        tcnt_d       = tcnt_q;
        acnt_d       = acnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_req) begin
                    state_d = ST_GRANT;
                    grant_d = pick ? 2'b10 : 2'b01;
                    tcnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    state_d  = ST_SEND;
                    data_d   = own_data;
                    last_d   = own_last;
                    enable_d = 1'b1;
                    tcnt_d   = '0;
                    acnt_d   = '0;
                end else if (tcnt_q >= T_LIMIT) begin
                    state_d      = ST_IDLE;
                    timeout_d    = 1'b1;
                    grant_d      = 2'b00;
                    last_owner_d = owner;
                end else begin
                    tcnt_d  = (tcnt_q == T_SAT) ? tcnt_q : tcnt_q + TW'(1);
                    // Ready is a single-cycle offer; inbound dbus traffic holds it off
                    ready_d = (owner ? 2'b10 : 2'b01)
                            & {2{own_valid & ~bus.i_dbusbusy & ~(|ready_q)}};
                end
            end
            ST_SEND: begin
                state_d = ST_ACK;
                acnt_d  = (acnt_q == A_SAT) ? acnt_q : acnt_q + AW'(1);
            end
            ST_ACK: begin
                if (bus.i_dbusbusy) begin
                    state_d = ST_DRAIN;
                end else if (acnt_q >= A_LIMIT) begin
                    state_d      = ST_IDLE;
                    timeout_d    = 1'b1;
                    grant_d      = 2'b00;
                    last_owner_d = owner;
                end else begin
                    acnt_d = (acnt_q == A_SAT) ? acnt_q : acnt_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (!bus.i_dbusbusy) begin
                    if (last_q) begin
                        state_d      = ST_IDLE;
                        grant_d      = 2'b00;
                        last_owner_d = owner;
                    end else begin
                        state_d = ST_GRANT;
                        tcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign bus.o_ready0     = ready_q[REQ_UART];
    assign bus.o_ready1     = ready_q[REQ_LOCAL];
    assign bus.o_dbusdata   = data_q;
    assign bus.o_dbusenable = enable_q;
    assign bus.o_grant      = grant_q;
    assign bus.o_timeout    = timeout_q;

endmodule

// File: tb/tb_dbus_tx_arbiter.sv
// tb/tb_dbus_tx_arbiter.sv - directed self-checking bench for dbus_tx_arbiter
module tb_dbus_tx_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dbus_tx_arbiter_if bus();

    dbus_tx_arbiter #(.c_TIMEOUT(8), .c_ACKWAIT(4)) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] sent_data[$];
    logic       sent_own[$];
    bit r0 = 0, r1 = 0, keep0 = 0, model_en = 1, force_busy = 0, bus_wait = 0;
    int busy_left = 0;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] rise_val = 2'b00;
    logic prev_tmo = 1'b0;
    int rises = 0, falls = 0, enables = 0, timeouts = 0;
    int rise_cyc = 0, fall_cyc = 0, tmo_cyc = 0, en_cyc = 0;
    int first_r1 = -1, ready0_cnt = 0, grant_bad = 0, tmo_long = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive();
        bus.i_req      = {r1 && (q1.size() != 0), r0 && (q0.size() != 0 || keep0)};
        bus.i_valid0   = (q0.size() != 0);
        bus.i_data0    = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        bus.i_last0    = (q0.size() != 0) ? q0[0][8] : 1'b0;
        bus.i_valid1   = (q1.size() != 0);
        bus.i_data1    = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        bus.i_last1    = (q1.size() != 0) ? q1[0][8] : 1'b0;
        bus.i_dbusbusy = force_busy || (busy_left > 0);
    endtask

    task automatic step();
        bit a0, a1;
        a0 = bus.i_valid0 && bus.o_ready0;
        a1 = bus.i_valid1 && bus.o_ready1;
        @(posedge clk); #1;
        cyc++;
        if (a0 && q0.size() != 0) void'(q0.pop_front());
        if (a1 && q1.size() != 0) void'(q1.pop_front());
        if (bus.o_ready0) ready0_cnt++;
        if (bus.o_ready1 && first_r1 < 0) first_r1 = cyc;
        if (bus.o_timeout) begin timeouts++; tmo_cyc = cyc; end
        if (bus.o_timeout && prev_tmo) tmo_long++;
        prev_tmo = bus.o_timeout;
        if (prev_grant == 2'b00 && bus.o_grant != 2'b00) begin rises++; rise_cyc = cyc; rise_val = bus.o_grant; end
        if (prev_grant != 2'b00 && bus.o_grant == 2'b00) begin falls++; fall_cyc = cyc; end
        if (prev_grant != 2'b00 && bus.o_grant != 2'b00 && bus.o_grant != prev_grant) grant_bad++;
        prev_grant = bus.o_grant;
        if (busy_left > 0) busy_left--;
        if (bus_wait) begin bus_wait = 0; busy_left = 10; end
        if (bus.o_dbusenable) begin
            enables++; en_cyc = cyc;
            sent_data.push_back(bus.o_dbusdata);
            sent_own.push_back(bus.o_grant[1]);
            if (model_en) bus_wait = 1;
        end
        drive();
    endtask

    task automatic wait_rise(input int budget, input string nm);
        int base = rises;
        for (int k = 0; k < budget && rises == base; k++) step();
        chk(nm, rises != base, 1);
    endtask

    task automatic wait_fall(input int budget, input string nm);
        int base = falls;
        for (int k = 0; k < budget && falls == base; k++) step();
        chk(nm, falls != base, 1);
    endtask

    task automatic wait_enable(input int budget, input string nm);
        int base = enables;
        for (int k = 0; k < budget && enables == base; k++) step();
        chk(nm, enables != base, 1);
    endtask

    task automatic wait_timeout(input int budget, input string nm);
        int base = timeouts;
        for (int k = 0; k < budget && timeouts == base; k++) step();
        chk(nm, timeouts != base, 1);
    endtask

    task automatic clear_logs();
        sent_data.delete();
        sent_own.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        r0 = 0; r1 = 0; keep0 = 0; force_busy = 0; bus_wait = 0; busy_left = 0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc++;
        prev_grant = bus.o_grant;
        prev_tmo = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_grant"}, bus.o_grant, 0);
        chk({pfx, "_ready0"}, bus.o_ready0, 0);
        chk({pfx, "_ready1"}, bus.o_ready1, 0);
        chk({pfx, "_enable"}, bus.o_dbusenable, 0);
        chk({pfx, "_data"}, bus.o_dbusdata, 0);
        chk({pfx, "_timeout"}, bus.o_timeout, 0);
    endtask

    initial begin
        vec_t tbl[6];
        logic [7:0] sb[3];
        logic [7:0] cd[4];
        int g, e, f, en_base;

        drive();
        @(posedge clk); #1;
        chk_outputs_zero("reset");
        do_reset();

        // single requester, three bytes
        sb[0] = 8'h2A; sb[1] = 8'h3B; sb[2] = 8'hC9;
        clear_logs();
        r0 = 1; q0.push_back({1'b0, 8'h2A}); q0.push_back({1'b0, 8'h3B}); q0.push_back({1'b1, 8'hC9});
        drive();
        wait_fall(300, "single_done");
        chk("single_count", sent_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (sent_data.size() > i) begin
                chk($sformatf("single_byte%0d", i), sent_data[i], sb[i]);
                chk($sformatf("single_own%0d", i), sent_own[i], 0);
            end
        end
        chk("single_grant", rise_val, 2'b01);
        chk("single_lock", grant_bad, 0);
        chk("single_grant_end", bus.o_grant, 2'b00);
        chk("single_no_timeout", timeouts, 0);
        r0 = 0; drive();

        // contention from reset: requester 0 packet first
        do_reset();
        clear_logs();
        cd[0] = 8'h10; cd[1] = 8'h11; cd[2] = 8'h20; cd[3] = 8'h21;
        r0 = 1; r1 = 1;
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
        drive();
        wait_fall(300, "cont_first_done");
        wait_fall(300, "cont_second_done");
        chk("cont_count", sent_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (sent_data.size() > i) begin
                chk($sformatf("cont_byte%0d", i), sent_data[i], cd[i]);
                chk($sformatf("cont_own%0d", i), sent_own[i], (i >= 2) ? 1 : 0);
            end
        end
        r0 = 0; r1 = 0; drive();
        step();

        // rotation table: single-byte packets
        tbl[0] = '{2'b11, 8'hA0, 8'hB0, 2'b01, 8'hA0};
        tbl[1] = '{2'b11, 8'hA1, 8'hB1, 2'b10, 8'hB1};
        tbl[2] = '{2'b01, 8'hA2, 8'hB2, 2'b01, 8'hA2};
        tbl[3] = '{2'b11, 8'hA3, 8'hB3, 2'b10, 8'hB3};
        tbl[4] = '{2'b10, 8'hA4, 8'hB4, 2'b10, 8'hB4};
        tbl[5] = '{2'b11, 8'hA5, 8'hB5, 2'b01, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            q0.delete(); q1.delete();
            r0 = tbl[i].req[0]; r1 = tbl[i].req[1];
            if (r0) q0.push_back({1'b1, tbl[i].d0});
            if (r1) q1.push_back({1'b1, tbl[i].d1});
            drive();
            wait_fall(100, $sformatf("tbl%0d_done", i));
            r0 = 0; r1 = 0; q0.delete(); q1.delete(); drive();
            chk($sformatf("tbl%0d_grant", i), rise_val, tbl[i].exp_grant);
            chk($sformatf("tbl%0d_count", i), sent_data.size(), 1);
            if (sent_data.size() > 0) chk($sformatf("tbl%0d_data", i), sent_data[0], tbl[i].exp_data);
            step();
        end

        // other requester arrives mid-packet
        clear_logs();
        first_r1 = -1;
        r0 = 1; q0.push_back({1'b0, 8'h50}); q0.push_back({1'b1, 8'h51});
        drive();
        wait_enable(100, "mid_first_byte");
        r1 = 1; q1.push_back({1'b1, 8'h60}); drive();
        wait_fall(200, "mid_pkt0_done");
        f = fall_cyc;
        chk("mid_pkt0_bytes", sent_data.size(), 2);
        wait_rise(10, "mid_regrant");
        chk("mid_regrant_val", rise_val, 2'b10);
        chk("mid_idle_gap", rise_cyc - f, 1);
        for (int k = 0; k < 10 && first_r1 < 0; k++) step();
        chk("mid_ready1_cycle", first_r1 - f, 2);
        wait_fall(200, "mid_pkt1_done");
        r0 = 0; r1 = 0; drive();
        step();

        // grant timeout with a pending other requester
        clear_logs();
        r0 = 1; keep0 = 1; r1 = 1; q1.push_back({1'b1, 8'h70});
        drive();
        wait_rise(10, "tmo_grant");
        g = rise_cyc;
        chk("tmo_grant_val", rise_val, 2'b01);
        wait_timeout(50, "tmo_fired");
        chk("tmo_delay", tmo_cyc - g, 8);
        chk("tmo_grant_cleared", bus.o_grant, 2'b00);
        step();
        chk("tmo_pulse_width", bus.o_timeout, 0);
        chk("tmo_next_grant", bus.o_grant, 2'b10);
        chk("tmo_next_gap", rise_cyc - tmo_cyc, 1);
        keep0 = 0; r0 = 0; drive();
        wait_fall(100, "tmo_req1_done");
        if (sent_data.size() > 0) chk("tmo_req1_data", sent_data[0], 8'h70);
        step();

        // ack loss: dbus never answers
        clear_logs();
        model_en = 0;
        r0 = 1; q0.push_back({1'b0, 8'h80}); q0.push_back({1'b1, 8'h81});
        drive();
        wait_enable(50, "ack_enable");
        e = en_cyc;
        wait_timeout(20, "ack_fired");
        chk("ack_delay", tmo_cyc - e, 4);
        chk("ack_grant_cleared", bus.o_grant, 2'b00);
        r0 = 0; q0.delete(); drive();
        repeat (10) step();
        chk("ack_no_resend", sent_data.size(), 1);
        model_en = 1;

        // inbound busy holds ready low while the timeout keeps counting
        clear_logs();
        force_busy = 1; ready0_cnt = 0;
        r0 = 1; q0.push_back({1'b1, 8'h90});
        drive();
        wait_rise(10, "busy_grant");
        g = rise_cyc;
        wait_timeout(50, "busy_timeout");
        chk("busy_ready0", ready0_cnt, 0);
        chk("busy_delay", tmo_cyc - g, 8);
        force_busy = 0; r0 = 0; q0.delete(); drive();
        step();

        // asynchronous reset during ACK
        clear_logs();
        model_en = 0;
        r1 = 1; q1.push_back({1'b0, 8'hA5}); q1.push_back({1'b1, 8'hA6});
        drive();
        wait_enable(50, "rst_enable");
        step();
        chk("rst_pre_grant", bus.o_grant, 2'b10);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("rst_async");
        q0.delete(); q1.delete(); bus_wait = 0; busy_left = 0;
        model_en = 1; r0 = 1; r1 = 1;
        q0.push_back({1'b1, 8'hB7}); q1.push_back({1'b1, 8'hC8});
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cyc++;
        prev_grant = 2'b00; prev_tmo = 1'b0;
        clear_logs();
        en_base = enables;
        wait_rise(10, "rst_regrant");
        chk("rst_regrant_val", rise_val, 2'b01);
        wait_enable(50, "rst_first_enable");
        if (sent_data.size() > 0) chk("rst_first_data", sent_data[0], 8'hB7);
        chk("rst_enable_count", enables - en_base, 1);
        chk("timeout_one_cycle", tmo_long, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
